// File: rtl/mac_row_seq.sv
// mac_row_seq: sequencer that feeds one mac_row instance.
//
// A job begins with start in IDLE, which latches cfg_len. The block then pulls
// col kernel weights followed by cfg_len activations from a valid/ready stream.
// Each accepted beat is re-issued to the row as registered in_w/inst_w. After
// the last activation, the row is held idle for DRAIN_CYC cycles so results can
// reach out_s. done then pulses for one cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   start     in   job request, sampled in IDLE only
//   cfg_len   in   activation count, latched when start is accepted
//   in_data   in   weight/activation stream data
//   in_valid  in   in_data is valid
//   in_ready  out  beat accepted this cycle when in_valid is also high
//   in_w      out  registered data to mac_row in_w
//   inst_w    out  registered instruction to mac_row ([0] kernel load, [1] execute)
//   busy      out  job in progress
//   done      out  one-cycle completion pulse
module mac_row_seq #(
    parameter int unsigned bw        = 4,
    parameter int unsigned col       = 8,
    parameter int unsigned LEN_BW    = 8,
    parameter int unsigned DRAIN_CYC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_BW-1:0] cfg_len,
    input  logic [bw-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [bw-1:0]     in_w,
    output logic [1:0]        inst_w,
    output logic              busy,
    output logic              done
);

    // The shared beat counter must hold the largest of: kernel beats, the
    // maximum activation count, and the drain window.
    localparam int unsigned LenMax  = (1 << LEN_BW) - 1;
    localparam int unsigned CntMaxA = (col > LenMax) ? col : LenMax;
    localparam int unsigned CntMax  = (CntMaxA > DRAIN_CYC) ? CntMaxA : DRAIN_CYC;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [CntW-1:0] LoadLast  = CntW'((col > 0) ? col - 1 : 0);
    // A zero drain window degenerates to a single drain cycle.
    localparam logic [CntW-1:0] DrainLast = CntW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    localparam logic [1:0] InstNop  = 2'b00;
    localparam logic [1:0] InstLoad = 2'b01;
    localparam logic [1:0] InstExec = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StExec,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LEN_BW-1:0] len_q, len_d;
    logic [bw-1:0]     in_w_q, in_w_d;
    logic [1:0]        inst_w_q, inst_w_d;
    logic              accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            len_q    <= '0;
            in_w_q   <= '0;
            inst_w_q <= InstNop;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            in_w_q   <= in_w_d;
            inst_w_q <= inst_w_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        in_w_d   = in_w_q;
        // Any cycle without an accepted beat issues a no-op to the row.
        inst_w_d = InstNop;

        in_ready = (state_q == StLoad) || (state_q == StExec);
        accept   = in_valid && in_ready;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end

            StLoad: begin
                if (accept) begin
                    in_w_d   = in_data;
                    inst_w_d = InstLoad;
                    if (cnt_q == LoadLast) begin
                        cnt_d   = '0;
                        state_d = (len_q == '0) ? StDrain : StExec;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end

            StExec: begin
                if (accept) begin
                    in_w_d   = in_data;
                    inst_w_d = InstExec;
                    // cnt_q < len_q here, so cnt_q + 1 never exceeds CntMax.
                    if ((cnt_q + CntOne) == CntW'(len_q)) begin
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end

            StDrain: begin
                if (cnt_q == DrainLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign in_w   = in_w_q;
    assign inst_w = inst_w_q;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_mac_row_seq.sv
// Directed bench for mac_row_seq (bw=4, col=8, LEN_BW=8, DRAIN_CYC=8).
// A small cycle model inside run_job tracks the expected handshake, row
// instruction, data and done timing; done edges are hand-computed per job.
module tb_mac_row_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] cfg_len;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_w;
    logic [1:0] inst_w;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_in_w = 4'h0;

    mac_row_seq #(
        .bw       (4),
        .col      (8),
        .LEN_BW   (8),
        .DRAIN_CYC(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cfg_len (cfg_len),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_w    (in_w),
        .inst_w  (inst_w),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".in_w"}, 32'(in_w), 32'h0);
        chk({tag, ".inst_w"}, 32'(inst_w), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".done"}, 32'(done), 32'h0);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'h0);
    endtask

    // Runs one job from IDLE. wb_at/ab_at: after that many weights/activations
    // hold in_valid low for wb_n/ab_n cycles (-1 disables). spulse: cycle index
    // (edges since t0) in which start is re-asserted. abort_at: cycle index in
    // which reset is asserted between edges (0 disables).
    task automatic run_job(input string name, input int len, input int wb_at, input int wb_n,
                           input int ab_at, input int ab_n, input int spulse,
                           input int abort_at, input int exp_done);
        int         wi, ai, dr, mst, edge_n, wb_left, ab_left, seen_done, n_load, n_exec;
        logic       v;
        logic [3:0] d;
        logic [1:0] exp_inst;
        wi = 0; ai = 0; dr = 0; edge_n = 0;
        wb_left = wb_n; ab_left = ab_n;
        seen_done = -1; n_load = 0; n_exec = 0;
        exp_inst = 2'b00;

        cfg_len  = 8'(len);
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        mst   = 0;  // 0 load, 1 exec, 2 drain, 3 done, 4 idle
        chk({name, ".busy_t0"}, 32'(busy), 32'h1);
        chk({name, ".ready_t0"}, 32'(in_ready), 32'h1);

        while (mst != 4) begin
            v = 1'b0;
            d = 4'h0;
            if (mst == 0) begin
                if (wi == wb_at && wb_left > 0) wb_left--;
                else begin
                    v = 1'b1;
                    d = 4'(15 - wi);
                end
            end else if (mst == 1) begin
                if (ai == ab_at && ab_left > 0) ab_left--;
                else begin
                    v = 1'b1;
                    d = 4'(ai + 1);
                end
            end
            in_valid = v;
            in_data  = d;
            start    = (edge_n == spulse);
            cfg_len  = (edge_n == spulse) ? 8'd2 : 8'(len);

            if (abort_at != 0 && edge_n == abort_at) begin
                #2;
                reset = 1'b0;
                #1;
                chk_zero({name, ".abort"});
                in_valid = 1'b0;
                start    = 1'b0;
                exp_in_w = 4'h0;
                return;
            end

            @(posedge clk);
            #1;
            edge_n++;

            case (mst)
                0: begin
                    if (v) begin
                        exp_in_w = d;
                        exp_inst = 2'b01;
                        wi++;
                        if (wi == 8) mst = (len == 0) ? 2 : 1;
                    end else exp_inst = 2'b00;
                end
                1: begin
                    if (v) begin
                        exp_in_w = d;
                        exp_inst = 2'b10;
                        ai++;
                        if (ai == len) mst = 2;
                    end else exp_inst = 2'b00;
                end
                2: begin
                    exp_inst = 2'b00;
                    dr++;
                    if (dr == 8) mst = 3;
                end
                default: begin
                    exp_inst = 2'b00;
                    mst = 4;
                end
            endcase

            chk({name, ".in_w"}, 32'(in_w), 32'(exp_in_w));
            chk({name, ".inst_w"}, 32'(inst_w), 32'(exp_inst));
            chk({name, ".in_ready"}, 32'(in_ready), 32'(mst <= 1));
            chk({name, ".busy"}, 32'(busy), 32'(mst != 4));
            chk({name, ".done"}, 32'(done), 32'(mst == 3));

            if (inst_w === 2'b01) n_load++;
            if (inst_w === 2'b10) n_exec++;
            if (done === 1'b1 && seen_done < 0) seen_done = edge_n;

            if (edge_n > 600) begin
                chk({name, ".timeout"}, 32'(edge_n), 32'd0);
                mst = 4;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        cfg_len  = 8'd0;
        chk({name, ".done_edge"}, 32'(seen_done), 32'(exp_done));
        chk({name, ".load_beats"}, 32'(n_load), 32'd8);
        chk({name, ".exec_beats"}, 32'(n_exec), 32'(len));
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        cfg_len  = 8'd0;
        in_data  = 4'h0;
        in_valid = 1'b0;

        // 1: outputs held at zero in reset and for 10 idle cycles after release.
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_held");
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk_zero("idle");
        end

        // 2: full job, continuous valid; done at t0+24.
        run_job("full", 8, -1, 0, -1, 0, -1, 0, 24);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_hold.in_w", 32'(in_w), 32'h8);
        chk("idle_hold.busy", 32'(busy), 32'h0);

        // 3: 3 bubbles after weight 4, 2 after activation 5; done at t0+29.
        run_job("bubble", 8, 4, 3, 5, 2, -1, 0, 29);
        @(posedge clk);
        #1;

        // 4: zero length; no execute beats, done at t0+16.
        run_job("zero_len", 0, -1, 0, -1, 0, -1, 0, 16);
        @(posedge clk);
        #1;

        // 5: start re-pulsed mid-EXEC, then asynchronous abort mid-EXEC.
        run_job("abort", 8, -1, 0, -1, 0, 11, 13, 0);
        @(posedge clk);
        #1;
        chk_zero("abort_hold");
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("post_abort");
        run_job("len3", 3, -1, 0, -1, 0, -1, 0, 19);
        @(posedge clk);
        #1;

        // 6: maximum length; 255 execute beats, done at t0+271.
        run_job("max_len", 255, -1, 0, -1, 0, -1, 0, 271);
        @(posedge clk);
        #1;
        chk("final.busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_row_seq.md
Name: mac_row_seq

Overview:
- Sequencer that drives one mac_row instance (clk, out_s, in_w, in_n, valid, inst_w, reset).
- Takes a start request and a job length. Pulls col kernel weights, then cfg_len activations, from an upstream valid/ready stream.
- Issues each beat to mac_row as registered in_w/inst_w: inst_w[0] is kernel load, inst_w[1] is execute.
- Idles the row for a fixed drain window so results reach out_s, then pulses done.

Parameters:
- bw, 4, weight/activation width; matches mac_row bw.
- col, 8, MAC count in the row; number of kernel weights per job.
- LEN_BW, 8, width of cfg_len.
- DRAIN_CYC, 8, idle cycles after the last execute beat before done.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled in IDLE only.
- cfg_len  in  LEN_BW  activation count; latched when start is accepted.
- in_data  in  bw  weight/activation stream data.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts in_data this cycle.
- in_w  out  bw  to mac_row in_w.
- inst_w  out  2  to mac_row inst_w.
- busy  out  1  job in progress (state != IDLE).
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; counters and the latched length clear.
  - Outputs are in_w=0, inst_w=00, busy=0, done=0, in_ready=0.
  - A reset mid-job aborts immediately; nothing is resumed.
- States: IDLE, LOAD, EXEC, DRAIN, DONE.
- IDLE:
  - start=1 at an edge latches cfg_len, clears beat_cnt, and moves to LOAD.
  - start outside IDLE is ignored; no queuing.
- in_ready is combinational: 1 exactly in LOAD and EXEC. A beat is accepted when in_valid & in_ready.
- LOAD:
  - Each accepted beat registers in_w<=in_data, inst_w<=01 and increments beat_cnt.
  - A non-accepted cycle registers inst_w<=00; in_w holds its value. mac_row treats 00 as a no-op.
  - Accepting beat number col clears beat_cnt and moves to EXEC, or to DRAIN if the latched length is 0.
- EXEC:
  - Same as LOAD but inst_w<=10.
  - Accepting beat number len clears beat_cnt and moves to DRAIN.
- DRAIN:
  - inst_w<=00 and in_ready=0.
  - beat_cnt counts edges; after DRAIN_CYC cycles in DRAIN, move to DONE.
- DONE:
  - done=1 for this single cycle, busy still 1.
  - Next edge moves to IDLE.
  - A start asserted during DONE is ignored.
- busy=1 in LOAD, EXEC, DRAIN, DONE.
- Latency, continuous in_valid, start sampled at edge t0:
  - Weights are accepted at t1..t(col) and appear on inst_w/in_w one cycle later.
  - Activations are accepted at t(col+1)..t(col+len).
  - done is high in the cycle after edge t0+col+len+DRAIN_CYC.
  - Each bubble cycle in LOAD/EXEC adds one cycle to this latency.
- beat_cnt is wide enough for max(col, 2^LEN_BW-1, DRAIN_CYC). cfg_len=2^LEN_BW-1 must not wrap.
- inst_w=11 is never produced.

Test Plan:
1. Reset/idle:
   - Hold reset=0, then release with start=0.
   - Required: in_w=0, inst_w=00, busy=0, done=0, in_ready=0, stable for 10 cycles.
2. Full job (col=8, DRAIN_CYC=8, cfg_len=8), in_valid held high:
   - Weights F,E,D,C,B,A,9,8 required on in_w with inst_w=01 for exactly 8 consecutive cycles.
   - Then activations 1..8 with inst_w=10 for 8 cycles.
   - Then inst_w=00 for 8 drain cycles.
   - done high exactly one cycle, starting at edge t0+24; busy falls the next cycle.
3. Bubbles:
   - Same job with in_valid=0 for 3 cycles after weight 4 and 2 cycles after activation 5.
   - Required: inst_w=00 during each bubble, no beat lost or duplicated, done at t0+29.
4. Zero length (cfg_len=0):
   - Required: 8 load beats, no inst_w=10 cycle, done at t0+16.
5. Start ignored and async abort:
   - start pulsed mid-EXEC changes nothing.
   - reset=0 asserted between edges mid-EXEC: outputs zero immediately without a clock edge.
   - After release, a new job with cfg_len=3 runs cleanly to done at t0+19.
6. Maximum length (cfg_len=255):
   - Required: exactly 255 inst_w=10 cycles with no counter wrap, done at t0+271.
